// File: rtl/pacman_dir_input.sv
// Pacman direction input: per-key debounce, registered press detection and a
// small state machine that turns debounced presses into a sticky direction request.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   resetN       synchronous reset, active-high (1 = reset)
//   key_raw      raw key levels, 1 = pressed, indexed by `RIGHT/`LEFT/`UP/`DOWN
//   game_started level, high once play begins
//   lost_life    one-cycle pulse on a life loss
//   req_dir      requested direction for the motion block
//   key_stable   debounced key levels, same indexing as key_raw
//   dir_changed  one-cycle pulse on the first cycle req_dir shows a new value

`ifndef RIGHT
`define RIGHT 2'd0
`endif
`ifndef LEFT
`define LEFT 2'd1
`endif
`ifndef UP
`define UP 2'd2
`endif
`ifndef DOWN
`define DOWN 2'd3
`endif

module pacman_dir_input #(
  parameter logic [15:0] DEBOUNCE_CLKS = 16'd50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] key_raw,
  input  logic       game_started,
  input  logic       lost_life,
  output logic [1:0] req_dir,
  output logic [3:0] key_stable,
  output logic       dir_changed
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DIR_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLKS - 16'd1);

  typedef enum logic [1:0] {
    WAIT_START_ST = 2'd0,
    ACTIVE_ST     = 2'd1,
    FROZEN_ST     = 2'd2
  } state_t;

  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] press_c;
  state_t              state;
  state_t              state_nxt;
  logic [DIR_W-1:0]    req_dir_nxt;
  logic [DIR_W-1:0]    win_dir_c;

  // Debounce: count cycles of disagreement, flip the stable level after DEBOUNCE_CLKS of them
  always_ff @(posedge clk) begin
    if (resetN) begin
      key_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_raw[i] == key_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]        <= '0;
          key_stable[i] <= ~key_stable[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered edge detect on the debounced levels
  always_ff @(posedge clk) begin
    if (resetN) key_prev <= '0;
    else        key_prev <= key_stable;
  end

  assign press_c = key_stable & ~key_prev;

  // Fixed priority RIGHT > LEFT > UP > DOWN: later assignments win
  always_comb begin
    win_dir_c = `LEFT;
    if (press_c[`DOWN])  win_dir_c = `DOWN;
    if (press_c[`UP])    win_dir_c = `UP;
    if (press_c[`LEFT])  win_dir_c = `LEFT;
    if (press_c[`RIGHT]) win_dir_c = `RIGHT;
  end

  // State and output registers; dir_changed flags the first cycle of a new req_dir
  always_ff @(posedge clk) begin
    if (resetN) begin
      state       <= WAIT_START_ST;
      req_dir     <= `LEFT;
      dir_changed <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_dir     <= req_dir_nxt;
      dir_changed <= (req_dir_nxt != req_dir);
    end
  end

  // Next state / next request
  always_comb begin
    state_nxt   = state;
    req_dir_nxt = req_dir;
    case (state)
      WAIT_START_ST: begin
        req_dir_nxt = `LEFT;
        if (game_started) state_nxt = ACTIVE_ST;
      end
      ACTIVE_ST: begin
        if (!game_started) begin
          state_nxt   = WAIT_START_ST;
          req_dir_nxt = `LEFT;
        end else if (lost_life) begin
          state_nxt   = FROZEN_ST;
          req_dir_nxt = `LEFT;
        end else if (|press_c) begin
          req_dir_nxt = win_dir_c;
        end
      end
      FROZEN_ST: begin
        // Presses are ignored until every key is released, so held keys cannot leak through
        if (!game_started) begin
          state_nxt   = WAIT_START_ST;
          req_dir_nxt = `LEFT;
        end else if (lost_life) begin
          req_dir_nxt = `LEFT;
        end else if (key_stable == '0) begin
          state_nxt = ACTIVE_ST;
        end
      end
      default: begin
        state_nxt   = WAIT_START_ST;
        req_dir_nxt = `LEFT;
      end
    endcase
  end

endmodule

// File: tb/tb_pacman_dir_input.sv
// Bench for pacman_dir_input: directed phase table with hand-derived end values,
// followed by random stimulus; every cycle is checked against a reference model.

module tb_pacman_dir_input;

  localparam int D = 8;
  localparam logic [1:0] D_RIGHT = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;
  localparam logic [1:0] D_DOWN  = 2'd3;
  localparam logic [3:0] K_RIGHT = 4'b0001;
  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_UP    = 4'b0100;
  localparam logic [3:0] K_DOWN  = 4'b1000;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic [3:0] key_raw = '0;
  logic       game_started = 1'b0;
  logic       lost_life = 1'b0;
  logic [1:0] req_dir;
  logic [3:0] key_stable;
  logic       dir_changed;

  int checks = 0;
  int errors = 0;

  pacman_dir_input #(.DEBOUNCE_CLKS(16'(D))) dut (
    .clk(clk), .resetN(resetN), .key_raw(key_raw), .game_started(game_started),
    .lost_life(lost_life), .req_dir(req_dir), .key_stable(key_stable),
    .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  // Reference model: run lengths of raw/stable disagreement and a play mode
  int         m_run [4];
  logic [3:0] m_stable = '0;
  logic [3:0] m_prev   = '0;
  logic [1:0] m_req    = D_LEFT;
  logic       m_chg    = 1'b0;
  int         m_mode   = 0; // 0 waiting, 1 playing, 2 frozen after a life loss

  task automatic model_step(input logic rst, input logic gs, input logic ll, input logic [3:0] raw);
    logic [3:0] press;
    logic [1:0] new_req;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_stable = '0; m_prev = '0; m_req = D_LEFT; m_chg = 1'b0; m_mode = 0;
      return;
    end
    press   = m_stable & ~m_prev;
    new_req = m_req;
    if (m_mode == 0) begin
      new_req = D_LEFT;
      if (gs) m_mode = 1;
    end else if (!gs) begin
      m_mode = 0; new_req = D_LEFT;
    end else if (ll) begin
      m_mode = 2; new_req = D_LEFT;
    end else if (m_mode == 1) begin
      // Direction codes are numbered in priority order, lowest wins
      for (int k = 3; k >= 0; k--) if (press[k]) new_req = 2'(k);
    end else if (m_stable == 4'b0000) begin
      m_mode = 1;
    end
    m_chg  = (new_req != m_req);
    m_req  = new_req;
    m_prev = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] == m_stable[i]) m_run[i] = 0;
      else m_run[i] = m_run[i] + 1;
      if (m_run[i] == D) begin
        m_stable[i] = ~m_stable[i];
        m_run[i] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic gs, input logic ll, input logic [3:0] raw);
    resetN = rst; game_started = gs; lost_life = ll; key_raw = raw;
    @(posedge clk);
    model_step(rst, gs, ll, raw);
    @(negedge clk);
    chk("model_req_dir", 32'(req_dir), 32'(m_req));
    chk("model_key_stable", 32'(key_stable), 32'(m_stable));
    chk("model_dir_changed", 32'(dir_changed), 32'(m_chg));
  endtask

  typedef struct {
    logic       rst;
    logic       gs;
    logic       ll;
    logic [3:0] raw;
    int         n;
    logic [1:0] e_req;
    logic [3:0] e_stable;
    logic       e_chg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic gs, input logic ll, input logic [3:0] raw,
                              input int n, input logic [1:0] e_req, input logic [3:0] e_stable,
                              input logic e_chg);
    vec_t v;
    v.rst = rst; v.gs = gs; v.ll = ll; v.raw = raw; v.n = n;
    v.e_req = e_req; v.e_stable = e_stable; v.e_chg = e_chg;
    tbl.push_back(v);
  endfunction

  initial begin
    logic gs_r;
    // rst gs ll raw n -> req stable chg (values after the last cycle of the row)
    add(1, 0, 0, 4'b0000,       2, D_LEFT,  4'b0000, 0); // reset
    add(0, 0, 0, K_UP,          7, D_LEFT,  4'b0000, 0); // UP not yet accepted
    add(0, 0, 0, K_UP,          1, D_LEFT,  K_UP,    0); // accepted after D cycles, no request
    add(0, 0, 0, 4'b0000,       8, D_LEFT,  4'b0000, 0);
    add(0, 1, 0, 4'b0000,       1, D_LEFT,  4'b0000, 0); // enter play
    add(0, 1, 0, K_RIGHT,       8, D_LEFT,  K_RIGHT, 0);
    add(0, 1, 0, K_RIGHT,       1, D_RIGHT, K_RIGHT, 1); // request appears with pulse
    add(0, 1, 0, K_RIGHT,       1, D_RIGHT, K_RIGHT, 0); // single pulse
    add(0, 1, 0, 4'b0000,      12, D_RIGHT, 4'b0000, 0); // sticky after release
    add(0, 1, 0, K_DOWN,        7, D_RIGHT, 4'b0000, 0); // short glitch
    add(0, 1, 0, 4'b0000,      10, D_RIGHT, 4'b0000, 0);
    add(0, 1, 0, K_UP | K_LEFT, 8, D_RIGHT, 4'b0110, 0);
    add(0, 1, 0, K_UP | K_LEFT, 1, D_LEFT,  4'b0110, 1); // LEFT beats UP
    add(0, 1, 0, 4'b0000,       9, D_LEFT,  4'b0000, 0);
    add(0, 1, 0, K_UP,          9, D_UP,    K_UP,    1);
    add(0, 1, 1, K_UP,          1, D_LEFT,  K_UP,    1); // life loss -> frozen
    add(0, 1, 0, K_UP,         10, D_LEFT,  K_UP,    0); // held key ignored
    add(0, 1, 0, 4'b0000,       8, D_LEFT,  4'b0000, 0);
    add(0, 1, 0, K_DOWN,        9, D_DOWN,  K_DOWN,  1); // thawed, DOWN accepted
    add(0, 1, 1, K_DOWN,        1, D_LEFT,  K_DOWN,  1);
    add(0, 1, 0, 4'b0000,       4, D_LEFT,  K_DOWN,  0); // mid-count while frozen
    add(1, 1, 0, 4'b0000,       1, D_LEFT,  4'b0000, 0); // reset discards progress
    add(0, 1, 0, 4'b0000,       1, D_LEFT,  4'b0000, 0);
    add(0, 1, 0, K_RIGHT,       9, D_RIGHT, K_RIGHT, 1);
    add(0, 0, 0, K_RIGHT,       1, D_LEFT,  K_RIGHT, 1); // game stop forces LEFT

    for (int r = 0; r < tbl.size(); r++) begin
      for (int c = 0; c < tbl[r].n; c++) cycle(tbl[r].rst, tbl[r].gs, tbl[r].ll, tbl[r].raw);
      chk($sformatf("row%0d_req_dir", r), 32'(req_dir), 32'(tbl[r].e_req));
      chk($sformatf("row%0d_key_stable", r), 32'(key_stable), 32'(tbl[r].e_stable));
      chk($sformatf("row%0d_dir_changed", r), 32'(dir_changed), 32'(tbl[r].e_chg));
    end

    // Random segments: held key patterns with sporadic life loss, game stop and reset
    gs_r = 1'b1;
    for (int s = 0; s < 200; s++) begin
      logic [3:0] raw;
      int n;
      raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) raw = 4'(1 << $urandom_range(0, 3));
      n = $urandom_range(1, 14);
      for (int c = 0; c < n; c++) begin
        logic rst, ll;
        if ($urandom_range(0, 60) == 0) gs_r = ~gs_r;
        ll  = ($urandom_range(0, 25) == 0);
        rst = ($urandom_range(0, 300) == 0);
        cycle(rst, gs_r, ll, raw);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
